// File: rtl/yadan_defs.sv
// Shared CSR addresses, WARL masks and misa constants for the yadan core.
package yadan_defs;

  localparam logic [11:0] CSR_SSCRATCH      = 12'h140;
  localparam logic [11:0] CSR_MSTATUS       = 12'h300;
  localparam logic [11:0] CSR_MISA          = 12'h301;
  localparam logic [11:0] CSR_MIE           = 12'h304;
  localparam logic [11:0] CSR_MTVEC         = 12'h305;
  localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
  localparam logic [11:0] CSR_MSCRATCH      = 12'h340;
  localparam logic [11:0] CSR_MEPC          = 12'h341;
  localparam logic [11:0] CSR_MCAUSE        = 12'h342;
  localparam logic [11:0] CSR_MTVAL         = 12'h343;
  localparam logic [11:0] CSR_MIP           = 12'h344;
  localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH       = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH     = 12'hB82;
  localparam logic [11:0] CSR_MHARTID       = 12'hF14;

  // mstatus field positions; MPP is hard-wired to machine mode
  localparam int MSTATUS_MIE_BIT  = 3;
  localparam int MSTATUS_MPIE_BIT = 7;
  localparam logic [31:0] MSTATUS_MPP_M  = 32'h0000_1800;

  localparam logic [31:0] MEPC_WMASK          = 32'hFFFF_FFFC;
  localparam logic [31:0] MTVEC_WMASK         = 32'hFFFF_FFFD;
  localparam logic [31:0] MCOUNTINHIBIT_WMASK = 32'h0000_0005;

  // MXL=1 (32-bit), extension I
  localparam logic [31:0] MISA_RV32I = 32'h4000_0100;

endpackage

// File: rtl/csr_counter.sv
// Free-running CNT_W-bit counter with inhibit and split low/high software loads.
module csr_counter #(
  parameter int CNT_W = 64,
  parameter int LO_W  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             inhibit,
  input  logic             we_lo,
  input  logic             we_hi,
  input  logic [LO_W-1:0]  wdata,
  output logic [CNT_W-1:0] cnt
);

  // A software load to either half wins over the increment; the other half holds.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (we_lo) begin
      cnt[LO_W-1:0] <= wdata;
    end else if (we_hi) begin
      cnt <= CNT_W'({wdata, cnt[LO_W-1:0]});
    end else if (inc && !inhibit) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR file with trap/mret handling and cycle counter.
// Define CSR_INSTRET_EN to add minstret/minstreth counting on retire_i.
module csr_file
  import yadan_defs::*;
#(
  parameter int XLEN    = 32,
  parameter int CNT_W   = 64,
  parameter int HART_ID = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we_i,
  input  logic [11:0]     waddr_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [11:0]     raddr_i,
  output logic [XLEN-1:0] rdata_o,
  output logic            illegal_o,
  input  logic            trap_i,
  input  logic [XLEN-1:0] trap_cause_i,
  input  logic [XLEN-1:0] trap_pc_i,
  input  logic [XLEN-1:0] trap_val_i,
  input  logic            mret_i,
  input  logic            retire_i,
  output logic [XLEN-1:0] trap_vector_o,
  output logic [XLEN-1:0] mepc_o,
  output logic            global_int_en_o
);

  localparam logic [XLEN-1:0] MEPC_M  = XLEN'(MEPC_WMASK);
  localparam logic [XLEN-1:0] MTVEC_M = XLEN'(MTVEC_WMASK);
  localparam logic [XLEN-1:0] MCI_M   = XLEN'(MCOUNTINHIBIT_WMASK);

  logic            mst_mie, mst_mpie;
  logic [XLEN-1:0] mie_q, mip_q, mtvec_q, mscratch_q, sscratch_q;
  logic [XLEN-1:0] mepc_q, mcause_q, mtval_q, mcountinhibit_q;
  logic [CNT_W-1:0] mcycle;

  logic [XLEN-1:0] mstatus_rd;
  logic [XLEN-1:0] cur_rd, wr_view;
  logic            cur_ill;

  function automatic logic wr_hit(input logic [11:0] a);
    return we_i && (waddr_i == a);
  endfunction

  // Trap beats mret beats software write for the trap-visible registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mst_mie  <= 1'b0;
      mst_mpie <= 1'b0;
      mepc_q   <= '0;
      mcause_q <= '0;
      mtval_q  <= '0;
    end else if (trap_i) begin
      mst_mpie <= mst_mie;
      mst_mie  <= 1'b0;
      mepc_q   <= trap_pc_i & MEPC_M;
      mcause_q <= trap_cause_i;
      mtval_q  <= trap_val_i;
    end else begin
      if (mret_i) begin
        mst_mie  <= mst_mpie;
        mst_mpie <= 1'b1;
      end else if (wr_hit(CSR_MSTATUS)) begin
        mst_mie  <= wdata_i[MSTATUS_MIE_BIT];
        mst_mpie <= wdata_i[MSTATUS_MPIE_BIT];
      end
      if (wr_hit(CSR_MEPC))   mepc_q   <= wdata_i & MEPC_M;
      if (wr_hit(CSR_MCAUSE)) mcause_q <= wdata_i;
      if (wr_hit(CSR_MTVAL))  mtval_q  <= wdata_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mie_q           <= '0;
      mip_q           <= '0;
      mtvec_q         <= '0;
      mscratch_q      <= '0;
      sscratch_q      <= '0;
      mcountinhibit_q <= '0;
    end else begin
      if (wr_hit(CSR_MIE))           mie_q           <= wdata_i;
      if (wr_hit(CSR_MIP))           mip_q           <= wdata_i;
      if (wr_hit(CSR_MTVEC))         mtvec_q         <= wdata_i & MTVEC_M;
      if (wr_hit(CSR_MSCRATCH))      mscratch_q      <= wdata_i;
      if (wr_hit(CSR_SSCRATCH))      sscratch_q      <= wdata_i;
      if (wr_hit(CSR_MCOUNTINHIBIT)) mcountinhibit_q <= wdata_i & MCI_M;
    end
  end

  csr_counter #(.CNT_W(CNT_W), .LO_W(XLEN)) u_mcycle (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc     (1'b1),
    .inhibit (mcountinhibit_q[0]),
    .we_lo   (wr_hit(CSR_MCYCLE)),
    .we_hi   (wr_hit(CSR_MCYCLEH)),
    .wdata   (wdata_i),
    .cnt     (mcycle)
  );

`ifdef CSR_INSTRET_EN
  logic [CNT_W-1:0] minstret;

  csr_counter #(.CNT_W(CNT_W), .LO_W(XLEN)) u_minstret (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc     (retire_i),
    .inhibit (mcountinhibit_q[2]),
    .we_lo   (wr_hit(CSR_MINSTRET)),
    .we_hi   (wr_hit(CSR_MINSTRETH)),
    .wdata   (wdata_i),
    .cnt     (minstret)
  );
`else
  logic unused_retire;
  assign unused_retire = retire_i;
`endif

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    mstatus_rd = XLEN'(MSTATUS_MPP_M);
    mstatus_rd[MSTATUS_MIE_BIT]  = mst_mie;
    mstatus_rd[MSTATUS_MPIE_BIT] = mst_mpie;
  end

  always_comb begin
    cur_rd  = '0;
    cur_ill = 1'b0;
    case (raddr_i)
      CSR_MSTATUS:       cur_rd = mstatus_rd;
      CSR_MISA:          cur_rd = XLEN'(MISA_RV32I);
      CSR_MIE:           cur_rd = mie_q;
      CSR_MIP:           cur_rd = mip_q;
      CSR_MTVEC:         cur_rd = mtvec_q;
      CSR_MSCRATCH:      cur_rd = mscratch_q;
      CSR_SSCRATCH:      cur_rd = sscratch_q;
      CSR_MEPC:          cur_rd = mepc_q;
      CSR_MCAUSE:        cur_rd = mcause_q;
      CSR_MTVAL:         cur_rd = mtval_q;
      CSR_MHARTID:       cur_rd = XLEN'(HART_ID);
      CSR_MCOUNTINHIBIT: cur_rd = mcountinhibit_q;
      CSR_MCYCLE:        cur_rd = mcycle[XLEN-1:0];
      CSR_MCYCLEH:       cur_rd = XLEN'(mcycle[CNT_W-1:XLEN]);
`ifdef CSR_INSTRET_EN
      CSR_MINSTRET:      cur_rd = minstret[XLEN-1:0];
      CSR_MINSTRETH:     cur_rd = XLEN'(minstret[CNT_W-1:XLEN]);
`endif
      default:           cur_ill = 1'b1;
    endcase
  end

  // What a read of waddr_i would return right after this write lands.
  always_comb begin
    wr_view = '0;
    case (waddr_i)
      CSR_MSTATUS: begin
        wr_view = XLEN'(MSTATUS_MPP_M);
        wr_view[MSTATUS_MIE_BIT]  = wdata_i[MSTATUS_MIE_BIT];
        wr_view[MSTATUS_MPIE_BIT] = wdata_i[MSTATUS_MPIE_BIT];
      end
      CSR_MISA:          wr_view = XLEN'(MISA_RV32I);
      CSR_MHARTID:       wr_view = XLEN'(HART_ID);
      CSR_MTVEC:         wr_view = wdata_i & MTVEC_M;
      CSR_MEPC:          wr_view = wdata_i & MEPC_M;
      CSR_MCOUNTINHIBIT: wr_view = wdata_i & MCI_M;
      CSR_MIE, CSR_MIP, CSR_MSCRATCH, CSR_SSCRATCH,
      CSR_MCAUSE, CSR_MTVAL, CSR_MCYCLE:
                         wr_view = wdata_i;
      CSR_MCYCLEH:       wr_view = XLEN'(wdata_i[CNT_W-XLEN-1:0]);
`ifdef CSR_INSTRET_EN
      CSR_MINSTRET:      wr_view = wdata_i;
      CSR_MINSTRETH:     wr_view = XLEN'(wdata_i[CNT_W-XLEN-1:0]);
`endif
      default:           wr_view = '0;
    endcase
  end

  assign rdata_o   = (we_i && (raddr_i == waddr_i)) ? wr_view : cur_rd;
  assign illegal_o = cur_ill;

  // Vectored mode only applies to interrupts (cause MSB set).
  always_comb begin
    trap_vector_o = {mtvec_q[XLEN-1:2], 2'b00};
    if (mtvec_q[0] && trap_cause_i[XLEN-1]) begin
      trap_vector_o = {mtvec_q[XLEN-1:2], 2'b00} + XLEN'({trap_cause_i[4:0], 2'b00});
    end
  end

  assign mepc_o          = mepc_q;
  assign global_int_en_o = mst_mie;

endmodule

// File: tb/tb_csr_file.sv
// Self-checking bench for csr_file: vector table plus trap/counter/reset sequences.
module tb_csr_file;
  import yadan_defs::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        we_i = 1'b0;
  logic [11:0] waddr_i = '0;
  logic [31:0] wdata_i = '0;
  logic [11:0] raddr_i = '0;
  logic [31:0] rdata_o;
  logic        illegal_o;
  logic        trap_i = 1'b0;
  logic [31:0] trap_cause_i = '0;
  logic [31:0] trap_pc_i = '0;
  logic [31:0] trap_val_i = '0;
  logic        mret_i = 1'b0;
  logic        retire_i = 1'b0;
  logic [31:0] trap_vector_o;
  logic [31:0] mepc_o;
  logic        global_int_en_o;

  csr_file #(.XLEN(32), .CNT_W(64), .HART_ID(0)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .we_i            (we_i),
    .waddr_i         (waddr_i),
    .wdata_i         (wdata_i),
    .raddr_i         (raddr_i),
    .rdata_o         (rdata_o),
    .illegal_o       (illegal_o),
    .trap_i          (trap_i),
    .trap_cause_i    (trap_cause_i),
    .trap_pc_i       (trap_pc_i),
    .trap_val_i      (trap_val_i),
    .mret_i          (mret_i),
    .retire_i        (retire_i),
    .trap_vector_o   (trap_vector_o),
    .mepc_o          (mepc_o),
    .global_int_en_o (global_int_en_o)
  );

  always #5 clk = ~clk;

`ifdef CSR_INSTRET_EN
  localparam logic INSTRET_ILL = 1'b0;
`else
  localparam logic INSTRET_ILL = 1'b1;
`endif

  typedef struct {
    logic        we;
    logic [11:0] waddr;
    logic [31:0] wdata;
    logic [11:0] raddr;
    logic [31:0] exp_rdata;
    logic        exp_ill;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] data;
    logic        ill;
    logic        chk_ill;
  } exp_t;

  vec_t vecs[16];
  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Pop the oldest expectation and compare against the live read port.
  task automatic sb_compare();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_empty: got 0 entries expected 1");
    end else begin
      e = sb.pop_front();
      check(e.name, rdata_o, e.data);
      if (e.chk_ill) check({e.name, "_illegal"}, {31'b0, illegal_o}, {31'b0, e.ill});
    end
  endtask

  task automatic peek(input logic [11:0] a, input logic [31:0] exp, input string name);
    raddr_i = a;
    sb.push_back('{name, exp, 1'b0, 1'b0});
    #1;
    sb_compare();
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    @(negedge clk);
    we_i = 1'b1; waddr_i = a; wdata_i = d;
    @(posedge clk); #1;
    we_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0]  = '{1'b0, 12'h000,            32'h0,         CSR_MISA,          32'h4000_0100, 1'b0};
    vecs[1]  = '{1'b0, 12'h000,            32'h0,         CSR_MHARTID,       32'h0,         1'b0};
    vecs[2]  = '{1'b0, 12'h000,            32'h0,         CSR_MSTATUS,       32'h0000_1800, 1'b0};
    vecs[3]  = '{1'b0, 12'h000,            32'h0,         12'h7C0,           32'h0,         1'b1};
    vecs[4]  = '{1'b1, CSR_MSCRATCH,       32'hA5,        CSR_MSCRATCH,      32'hA5,        1'b0};
    vecs[5]  = '{1'b0, 12'h000,            32'h0,         CSR_MSCRATCH,      32'hA5,        1'b0};
    vecs[6]  = '{1'b1, CSR_MSTATUS,        32'hFFFF_FFFF, CSR_MSTATUS,       32'h0000_1888, 1'b0};
    vecs[7]  = '{1'b0, 12'h000,            32'h0,         CSR_MSTATUS,       32'h0000_1888, 1'b0};
    vecs[8]  = '{1'b1, CSR_MSTATUS,        32'h0,         CSR_MSTATUS,       32'h0000_1800, 1'b0};
    vecs[9]  = '{1'b1, CSR_MEPC,           32'h1237,      CSR_MEPC,          32'h1234,      1'b0};
    vecs[10] = '{1'b1, CSR_MCOUNTINHIBIT,  32'hFFFF_FFFF, CSR_MCOUNTINHIBIT, 32'h5,         1'b0};
    vecs[11] = '{1'b1, CSR_MCOUNTINHIBIT,  32'h0,         CSR_MCOUNTINHIBIT, 32'h0,         1'b0};
    vecs[12] = '{1'b1, CSR_SSCRATCH,       32'h5A5A,      CSR_MSCRATCH,      32'hA5,        1'b0};
    vecs[13] = '{1'b0, 12'h000,            32'h0,         CSR_SSCRATCH,      32'h5A5A,      1'b0};
    vecs[14] = '{1'b1, CSR_MISA,           32'h0,         CSR_MISA,          32'h4000_0100, 1'b0};
    vecs[15] = '{1'b1, CSR_MTVEC,          32'h0000_0103, CSR_MTVEC,         32'h0000_0101, 1'b0};

    // Reset state
    #12;
    check("rst_trap_vector", trap_vector_o, 32'h0);
    check("rst_mepc_o", mepc_o, 32'h0);
    check("rst_gie", {31'b0, global_int_en_o}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Vector table, checked combinationally before the write commits
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      we_i = vecs[i].we; waddr_i = vecs[i].waddr; wdata_i = vecs[i].wdata;
      raddr_i = vecs[i].raddr;
      sb.push_back('{$sformatf("vec%0d", i), vecs[i].exp_rdata, vecs[i].exp_ill, 1'b1});
      #1;
      sb_compare();
      @(posedge clk); #1;
      we_i = 1'b0;
    end
    @(negedge clk);
    peek(CSR_MINSTRET, 32'h0, "minstret_idle");
    checks++;
    if (illegal_o !== INSTRET_ILL) begin
      failures++;
      $display("FAIL minstret_illegal: got %0b expected %0b", illegal_o, INSTRET_ILL);
    end

    // Trap vector: vectored interrupt vs synchronous exception
    wr(CSR_MTVEC, 32'h8000_0101);
    @(negedge clk);
    trap_i = 1'b1; trap_cause_i = 32'h8000_0007; trap_pc_i = 32'h100; trap_val_i = 32'h0;
    #1 check("tvec_vectored", trap_vector_o, 32'h8000_011C);
    trap_cause_i = 32'h2;
    #1 check("tvec_exception", trap_vector_o, 32'h8000_0100);
    @(posedge clk); #1;
    trap_i = 1'b0;

    // Trap entry and mret on mstatus/mepc
    wr(CSR_MSTATUS, 32'h8);
    check("gie_set", {31'b0, global_int_en_o}, 32'h1);
    @(negedge clk);
    trap_i = 1'b1; trap_cause_i = 32'h2; trap_pc_i = 32'h1002; trap_val_i = 32'h77;
    @(posedge clk); #1;
    trap_i = 1'b0;
    peek(CSR_MSTATUS, 32'h0000_1880, "trap_mstatus");
    peek(CSR_MEPC, 32'h1000, "trap_mepc");
    peek(CSR_MCAUSE, 32'h2, "trap_mcause");
    peek(CSR_MTVAL, 32'h77, "trap_mtval");
    check("trap_mepc_o", mepc_o, 32'h1000);
    check("trap_gie", {31'b0, global_int_en_o}, 32'h0);
    @(negedge clk);
    mret_i = 1'b1;
    @(posedge clk); #1;
    mret_i = 1'b0;
    peek(CSR_MSTATUS, 32'h0000_1888, "mret_mstatus");

    // Trap beats a software mepc write; an unrelated write still lands
    @(negedge clk);
    trap_i = 1'b1; trap_pc_i = 32'h2000; we_i = 1'b1; waddr_i = CSR_MEPC; wdata_i = 32'h40;
    @(posedge clk); #1;
    trap_i = 1'b0; we_i = 1'b0;
    check("trap_vs_we_mepc", mepc_o, 32'h2000);
    @(negedge clk);
    trap_i = 1'b1; trap_pc_i = 32'h3000; we_i = 1'b1; waddr_i = CSR_MSCRATCH; wdata_i = 32'h55;
    @(posedge clk); #1;
    trap_i = 1'b0; we_i = 1'b0;
    peek(CSR_MSCRATCH, 32'h55, "trap_with_mscratch");
    check("trap2_mepc", mepc_o, 32'h3000);

    // Counter carry from low to high half, then inhibit
    wr(CSR_MCYCLE, 32'hFFFF_FFFF);
    wr(CSR_MCYCLEH, 32'h0);
    @(posedge clk);
    @(posedge clk); #1;
    peek(CSR_MCYCLEH, 32'h1, "mcycleh_carry");
    peek(CSR_MCYCLE, 32'h1, "mcycle_carry");
    wr(CSR_MCOUNTINHIBIT, 32'h1);
    repeat (4) @(posedge clk);
    #1;
    peek(CSR_MCYCLE, 32'h2, "mcycle_frozen");
    peek(CSR_MCYCLEH, 32'h1, "mcycleh_frozen");
    wr(CSR_MCOUNTINHIBIT, 32'h0);

    // Reset in the middle of a cycle while counting
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    peek(CSR_MCYCLE, 32'h0, "rst_mcycle");
    peek(CSR_MCYCLEH, 32'h0, "rst_mcycleh");
    peek(CSR_MISA, 32'h4000_0100, "rst_misa");
    peek(CSR_MSTATUS, 32'h0000_1800, "rst_mstatus");
    peek(CSR_MSCRATCH, 32'h0, "rst_mscratch");
    @(negedge clk);
    rst_n = 1'b1;

`ifdef CSR_INSTRET_EN
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      retire_i = 1'b1;
      @(posedge clk); #1;
      retire_i = 1'b0;
    end
    @(negedge clk);
    peek(CSR_MINSTRET, 32'h3, "minstret_count");
    peek(CSR_MINSTRETH, 32'h0, "minstreth_count");
`else
    @(negedge clk);
    retire_i = 1'b1;
    @(posedge clk); #1;
    retire_i = 1'b0;
    peek(CSR_MINSTRET, 32'h0, "minstret_absent");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
